// File: rtl/div_line.sv
// div_line: fully pipelined unsigned restoring divider, one quotient bit per rank.
// Rank 0 registers the operands, ranks 1..DIVIDEND_LEN each retire one dividend bit.
module div_line #(
  parameter int DIVIDEND_LEN = 16,
  parameter int DIVISOR_LEN  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic [DIVIDEND_LEN-1:0] dividend,
  input  logic [DIVISOR_LEN-1:0]  divisor,
  output logic [DIVIDEND_LEN-1:0] quot,
  output logic [DIVISOR_LEN-1:0]  rem,
  output logic                    div_zero,
  output logic                    valid
);

  localparam int N = DIVIDEND_LEN;
  localparam int M = DIVISOR_LEN;

  // Streaming handshake: rdy=1 at an edge means the operands are taken at that
  // edge, with no backpressure. valid is rdy delayed by exactly N edges. When
  // valid=1 the quot/rem/div_zero outputs carry that sample's result. When
  // valid=0 they keep the last result (or zero after reset).

  // Ranks 0..N-1 are the operand register and the intermediate steps. Rank N is
  // the output register below.
  logic [N-1:0]        r_vld;
  logic [N-1:0]        r_zero;
  logic [N-1:0][M-1:0] r_dvs;
  logic [N-1:0][N-1:0] r_dvd;
  logic [N-1:0][N-1:0] r_quo;
  logic [N-1:0][M:0]   r_pr;

  logic [N-1:0] r_quot_o;
  logic [M-1:0] r_rem_o;
  logic         r_dz_o;
  logic         r_vld_o;

  // Step k consumes the state of rank k-1.
  logic [N:1][M:0] w_shift;
  logic [N:1][M:0] w_diff;
  logic [N:1][M:0] w_pr_nx;
  logic [N:1]      w_ge;
  logic            w_unused;

  always_comb begin
    w_shift = '0;
    w_diff  = '0;
    w_pr_nx = '0;
    w_ge    = '0;
    for (int k = 1; k <= N; k++) begin
      w_shift[k] = {r_pr[k-1][M-1:0], r_dvd[k-1][N-1]};
      w_ge[k]    = (w_shift[k] >= {1'b0, r_dvs[k-1]});
      w_diff[k]  = w_shift[k] - {1'b0, r_dvs[k-1]};
      w_pr_nx[k] = w_ge[k] ? w_diff[k] : w_shift[k];
    end
  end

  // The partial remainder stays below the divisor, so its top bit is always
  // zero. The upper quotient bits and the leftover dividend bits are never
  // read. They are folded into one sink so that nothing dangles.
  always_comb begin
    w_unused = ^r_dvd[N-1][N-2:0] ^ w_pr_nx[N][M];
    for (int k = 0; k < N; k++) begin
      w_unused = w_unused ^ r_quo[k][N-1] ^ r_pr[k][M];
    end
  end

  always_ff @(posedge clk) begin
    // Rank 0 loads unconditionally, so a bubble carries don't-care operands.
    r_vld[0]  <= rst_n & rdy;
    r_zero[0] <= (divisor == '0);
    r_dvs[0]  <= divisor;
    r_dvd[0]  <= dividend;
    r_quo[0]  <= '0;
    r_pr[0]   <= '0;

    for (int k = 1; k < N; k++) begin
      r_vld[k] <= rst_n & r_vld[k-1];
      if (r_vld[k-1]) begin
        r_zero[k] <= r_zero[k-1];
        r_dvs[k]  <= r_dvs[k-1];
        r_dvd[k]  <= r_dvd[k-1] << 1;
        r_quo[k]  <= {r_quo[k-1][N-2:0], w_ge[k]};
        r_pr[k]   <= w_pr_nx[k];
      end
    end

    if (!rst_n) begin
      r_vld_o  <= 1'b0;
      r_quot_o <= '0;
      r_rem_o  <= '0;
      r_dz_o   <= 1'b0;
    end else begin
      r_vld_o <= r_vld[N-1];
      if (r_vld[N-1]) begin
        // A zero divisor gives a fixed result that does not depend on the dividend.
        r_quot_o <= r_zero[N-1] ? '1 : {r_quo[N-1][N-2:0], w_ge[N]};
        r_rem_o  <= r_zero[N-1] ? '0 : w_pr_nx[N][M-1:0];
        r_dz_o   <= r_zero[N-1];
      end
    end
  end

  assign quot     = r_quot_o;
  assign rem      = r_rem_o;
  assign div_zero = r_dz_o;
  assign valid    = r_vld_o;

endmodule
